multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath (pc_counter, register32, alu_cpu, memory). It decodes the instruction opcode into a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the write enables, mux selects and memory strobes that are currently hard-wired, so the single memory port is shared between instruction fetch and load/store. It raises `createdump` on halt and keeps a retired-instruction count.

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/mem_wait_counter.sv | 21 ++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic PC_SRC_PLUS4  = 1'b0;
  localparam logic PC_SRC_BRANCH = 1'b1;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Only BEQ/BNE are resolved here; other branch kinds fall through as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      F3_BEQ:  return zero;
      F3_BNE:  return !zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter timing memory wait states; done while the count is zero.
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                     cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - 3'd1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb, arbitrates the memory port.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  output logic        pc_we,
  output logic        pc_src,
  output logic        ir_we,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        createdump,
  output logic        halted,
  output logic [31:0] instret
);

  localparam int unsigned WAIT_LW   = (MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1;
  localparam logic [2:0]  WAIT_INIT = WAIT_LW[2:0];
  localparam logic        NO_WAIT   = (MEM_LATENCY == 0);

  state_t state, next_state;
  logic   cnt_load, cnt_done, retire, dumped;

  mem_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (state == S_FETCH_WAIT || state == S_MEM_WAIT),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Remembers that the first HALT cycle has passed, so createdump is a single pulse.
  always_ff @(posedge clk) begin
    if (!rst)                 dumped <= 1'b0;
    else if (state == S_HALT) dumped <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)        instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    retire     = 1'b0;
    unique case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (NO_WAIT) next_state = S_DECODE;
        else begin
          cnt_load   = 1'b1;
          next_state = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: if (cnt_done) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: next_state = S_EXEC;
          OP_SYSTEM: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          OP_RTYPE, OP_IALU: next_state = S_WB;
          OP_LOAD, OP_STORE: next_state = S_MEM;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEM, S_MEM_WAIT: begin
        if (state == S_MEM && !NO_WAIT) begin
          cnt_load   = 1'b1;
          next_state = S_MEM_WAIT;
        end else if (state == S_MEM || cnt_done) begin
          if (opcode == OP_STORE) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    pc_src     = PC_SRC_PLUS4;
    ir_we      = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_OP_ADD;
    reg_we     = 1'b0;
    wb_sel     = WB_SEL_ALU;
    createdump = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_FETCH, S_FETCH_WAIT: begin
        mem_en = 1'b1;
        if ((state == S_FETCH && NO_WAIT) || (state == S_FETCH_WAIT && cnt_done)) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: alu_op = ALU_OP_FUNCT;
          OP_IALU: begin
            alu_op    = ALU_OP_FUNCT;
            alu_src_b = 1'b1;
          end
          OP_LOAD, OP_STORE: alu_src_b = 1'b1;
          OP_BRANCH: begin
            alu_op = ALU_OP_SUB;
            if (branch_taken(funct3, zero)) begin
              pc_we  = 1'b1;
              pc_src = PC_SRC_BRANCH;
            end
          end
          default: ;
        endcase
      end
      S_MEM, S_MEM_WAIT: begin
        mem_en   = 1'b1;
        addr_sel = 1'b1;
        mem_wr   = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_we = (opcode == OP_RTYPE) || (opcode == OP_IALU) || (opcode == OP_LOAD);
        wb_sel = (opcode == OP_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
      end
      S_HALT: begin
        halted     = 1'b1;
        createdump = !dumped;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl at memory latencies 0, 2 and 3 against a cycle-trace model.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011, B_OP = 7'b1100011, SYS_OP = 7'b1110011;

  // Output vector: {pc_we,pc_src,ir_we,mem_en,mem_wr,addr_sel,alu_src_b,alu_op,reg_we,wb_sel,createdump,halted}
  localparam logic [12:0] PCWE = 13'h1000, PCSRC = 13'h0800, IRWE = 13'h0400, MEMEN = 13'h0200;
  localparam logic [12:0] MEMWR = 13'h0100, ADDR = 13'h0080, SRCB = 13'h0040, AOP_FN = 13'h0020;
  localparam logic [12:0] AOP_SUB = 13'h0010, REGWE = 13'h0008, WBSEL = 13'h0004;
  localparam logic [12:0] DUMP = 13'h0002, HALTED = 13'h0001;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic [6:0]  op_s [3];
  logic [2:0]  f3_s [3];
  logic        z_s [3];
  logic [12:0] ov [3];
  logic [31:0] ir [3];

  int errors = 0;
  int checks = 0;
  int exp_cnt [3];

  typedef struct {logic [12:0] v; bit ret;} cyc_t;
  cyc_t q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LV = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic pc_we, pc_src, ir_we, mem_en, mem_wr, addr_sel, alu_src_b, reg_we, wb_sel, createdump, halted;
    logic [1:0]  alu_op;
    logic [31:0] instret;
    multicycle_ctrl #(.MEM_LATENCY(LV)) u_dut (
      .clk(clk), .rst(rst_n[g]), .opcode(op_s[g]), .funct3(f3_s[g]), .zero(z_s[g]),
      .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_en(mem_en), .mem_wr(mem_wr),
      .addr_sel(addr_sel), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
      .wb_sel(wb_sel), .createdump(createdump), .halted(halted), .instret(instret)
    );
    assign ov[g] = {pc_we, pc_src, ir_we, mem_en, mem_wr, addr_sel, alu_src_b, alu_op,
                    reg_we, wb_sel, createdump, halted};
    assign ir[g] = instret;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [12:0] v, input bit r);
    cyc_t c;
    c.v = v;
    c.ret = r;
    q.push_back(c);
  endfunction

  // Expected per-cycle outputs of one instruction, built from the latency rules.
  function automatic void model(input int L, input logic [6:0] op, input logic [2:0] f3,
                                input logic z, input int nhalt);
    bit taken;
    q.delete();
    push((L == 0) ? (MEMEN | IRWE | PCWE) : MEMEN, 1'b0);
    for (int i = 1; i <= L; i++) push((i == L) ? (MEMEN | IRWE | PCWE) : MEMEN, 1'b0);
    if (op == SYS_OP) begin
      push('0, 1'b1);
      push(DUMP | HALTED, 1'b0);
      for (int i = 1; i < nhalt; i++) push(HALTED, 1'b0);
      return;
    end
    push('0, 1'b0);
    case (op)
      R_OP: begin push(AOP_FN, 1'b0); push(REGWE, 1'b1); end
      I_OP: begin push(AOP_FN | SRCB, 1'b0); push(REGWE, 1'b1); end
      L_OP, S_OP: begin
        push(SRCB, 1'b0);
        for (int i = 0; i <= L; i++)
          push(MEMEN | ADDR | ((op == S_OP) ? MEMWR : 13'h0), (op == S_OP) && (i == L));
        if (op == L_OP) push(REGWE | WBSEL, 1'b1);
      end
      B_OP: begin
        taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        push(AOP_SUB | (taken ? (PCWE | PCSRC) : 13'h0), 1'b1);
      end
      default: ;
    endcase
  endfunction

  task automatic reset_dut(input int d);
    rst_n[d] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_outputs", 32'(ov[d]), 32'h0);
    chk("reset_instret", ir[d], 32'h0);
    exp_cnt[d] = 0;
    rst_n[d] = 1'b1;
    chk("idle_outputs", 32'(ov[d]), 32'h0);
    @(posedge clk); #1;
  endtask

  // Runs one instruction from FETCH; stop_at limits how many trace cycles are checked.
  task automatic run_instr(input int d, input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input int nhalt, input int stop_at);
    int n;
    op_s[d] = op;
    f3_s[d] = f3;
    z_s[d]  = z;
    model(lat(d), op, f3, z, nhalt);
    n = (stop_at < 0) ? q.size() : stop_at;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("ctl d%0d op%b c%0d", d, op, i), 32'(ov[d]), 32'(q[i].v));
      chk($sformatf("instret d%0d c%0d", d, i), ir[d], exp_cnt[d]);
      if (q[i].ret) exp_cnt[d]++;
      if (i < n - 1 || stop_at < 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic rand_instr(input int d);
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = R_OP;
      1: op = I_OP;
      2: op = L_OP;
      3: op = S_OP;
      4, 5: op = B_OP;
      default: begin
        op = 7'($urandom);
        while (op inside {R_OP, I_OP, L_OP, S_OP, B_OP, SYS_OP}) op = 7'($urandom);
      end
    endcase
    run_instr(d, op, 3'($urandom_range(0, 2)), 1'($urandom), 0, -1);
  endtask

  task automatic halt_test(input int d);
    run_instr(d, SYS_OP, 3'b000, 1'b0, 20, 20 + lat(d) + 2);
    rst_n[d] = 1'b0;
    @(posedge clk); #1;
    chk("halt_cleared", 32'(ov[d]), 32'h0);
    chk("halt_instret_cleared", ir[d], 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      op_s[d] = '0;
      f3_s[d] = '0;
      z_s[d] = 1'b0;
      exp_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Latency 0: R-type loop, directed branches and illegal opcode, then random mix.
    reset_dut(0);
    for (int i = 0; i < 3; i++) run_instr(0, R_OP, 3'b000, 1'b0, 0, -1);
    chk("rtype_instret_3", ir[0], 32'd3);
    run_instr(0, B_OP, 3'b000, 1'b1, 0, -1);
    run_instr(0, B_OP, 3'b000, 1'b0, 0, -1);
    run_instr(0, B_OP, 3'b001, 1'b1, 0, -1);
    run_instr(0, B_OP, 3'b001, 1'b0, 0, -1);
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 0, -1);
    for (int i = 0; i < 30; i++) rand_instr(0);
    halt_test(0);

    // Latency 2: directed load, then random mix and halt.
    reset_dut(1);
    run_instr(1, L_OP, 3'b010, 1'b0, 0, -1);
    chk("load_instret", ir[1], 32'd1);
    for (int i = 0; i < 30; i++) rand_instr(1);
    halt_test(1);

    // Latency 3: random mix, then reset abandoning a store inside MEM_WAIT.
    reset_dut(2);
    for (int i = 0; i < 20; i++) rand_instr(2);
    run_instr(2, R_OP, 3'b000, 1'b0, 0, -1);
    run_instr(2, S_OP, 3'b010, 1'b0, 0, 1 + 3 + 1 + 1 + 1 + 1);
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    chk("store_reset_outputs", 32'(ov[2]), 32'h0);
    chk("store_reset_instret", ir[2], 32'h0);
    reset_dut(2);
    for (int i = 0; i < 10; i++) rand_instr(2);
    halt_test(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
